// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, word length and receiver state encoding.
// Used by the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned CLK_DIV_DEF  = 104;
  localparam int unsigned WORD_LEN_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  // Completion events, registered and presented for exactly one cycle.
  typedef struct packed {
    logic dv;
    logic frame_err;
  } uart_rx_evt_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops reset to p_RST_VAL.
module uart_sync #(
  parameter logic p_RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= p_RST_VAL;
      o_q  <= p_RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit centre alignment, p_WORD_LEN+1 data bits, one stop bit.
// Define UART_RX_PARITY_EN to check bit p_WORD_LEN as even parity over the lower bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned p_CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned p_WORD_LEN = WORD_LEN_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  output logic [p_WORD_LEN:0]   o_data,
  output logic                  o_dv,
  output logic                  o_active,
  output logic                  o_frame_err,
  output logic                  o_parity_err
);

  localparam int CNT_W = $clog2(p_CLK_DIV) + 1;
  localparam int BIT_W = $clog2(p_WORD_LEN) + 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(p_CLK_DIV / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(p_CLK_DIV);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(p_WORD_LEN);

  logic                rx_s, rx_prev_q, fall;
  logic [2:0]          warm_q;
  uart_state_e         state_q, state_d;
  logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [p_WORD_LEN:0] shadow_q, shadow_d, data_q;
  logic                load;
  logic                active_q, active_d;
  uart_rx_evt_t        evt_q, evt_d;

  uart_sync #(.p_RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Edge detection stays disarmed until the synchronizer and rx_prev hold real
  // line samples, so a line caught low at reset release is not taken as a start.
  assign fall = warm_q[2] & rx_prev_q & ~rx_s;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    evt_d     = '0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL) begin
          clk_cnt_d = '0;
          for (int i = 0; i <= int'(p_WORD_LEN); i++)
            if (bit_cnt_q == BIT_W'(i)) shadow_d[i] = rx_s;
          if (bit_cnt_q == LAST) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == FULL) begin
          clk_cnt_d = '0;
          state_d   = DONE;
          if (rx_s) begin
            load     = 1'b1;
            evt_d.dv = 1'b1;
          end else begin
            evt_d.frame_err = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      active_q  <= 1'b0;
      evt_q     <= '0;
      rx_prev_q <= 1'b1;
      warm_q    <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      evt_q     <= evt_d;
      rx_prev_q <= rx_s;
      warm_q    <= {warm_q[1:0], 1'b1};
      if (load) data_q <= shadow_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;

  // Parity is only judged on frames that are delivered, alongside o_dv.
  always_comb begin
    par_err_d = 1'b0;
    if (load) par_err_d = shadow_q[p_WORD_LEN] ^ (^shadow_q[p_WORD_LEN-1:0]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) par_err_q <= 1'b0;
    else          par_err_q <= par_err_d;
  end

  assign o_parity_err = par_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = data_q;
  assign o_dv        = evt_q.dv;
  assign o_frame_err = evt_q.frame_err;
  assign o_active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (105-cycle bit, 9-bit word).
module tb_uart_rx;

  localparam int BIT = 105;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [8:0] o_data;
  logic       o_dv, o_active, o_frame_err, o_parity_err;

  int total = 0;
  int bad   = 0;

  int dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0, long_cnt = 0;
  logic dv_d = 1'b0, fe_d = 1'b0;
  logic [8:0] dq[$];

  uart_rx dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .o_data       (o_data),
    .o_dv         (o_dv),
    .o_active     (o_active),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor: sole writer of the counters and received-word queue.
  always @(negedge clk) begin
    if (o_dv) begin
      dv_cnt = dv_cnt + 1;
      dq.push_back(o_data);
    end
    if (o_frame_err)  ferr_cnt = ferr_cnt + 1;
    if (o_parity_err) perr_cnt = perr_cnt + 1;
    if ((o_dv && dv_d) || (o_frame_err && fe_d)) long_cnt = long_cnt + 1;
    dv_d = o_dv;
    fe_d = o_frame_err;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 9; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (o_data !== 9'h000) begin bad++; $display("FAIL reset_data: got %h want 000", o_data); end
    total++; if ({o_dv, o_active, o_frame_err, o_parity_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {o_dv, o_active, o_frame_err, o_parity_err}); end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_loopback;
    int b, f, p, q0;
    b = dv_cnt; f = ferr_cnt; p = perr_cnt; q0 = dq.size();
    send_frame(9'h0A5, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (dv_cnt - b !== 1) begin bad++; $display("FAIL loop_dv_count: got %0d want 1", dv_cnt - b); end
    total++; if (dq.size() <= q0 || dq[q0] !== 9'h0A5) begin bad++; $display("FAIL loop_dv_data: got %h want 0a5", (dq.size() > q0) ? dq[q0] : 9'h1xx); end
    total++; if (o_data !== 9'h0A5) begin bad++; $display("FAIL loop_hold: got %h want 0a5", o_data); end
    total++; if (ferr_cnt - f !== 0 || perr_cnt - p !== 0) begin
      bad++; $display("FAIL loop_err: got ferr=%0d perr=%0d want 0 0", ferr_cnt - f, perr_cnt - p); end
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL loop_idle: got active=%b want 0", o_active); end
  endtask

  task automatic test_glitch;
    int b, f, n;
    b = dv_cnt; f = ferr_cnt;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    rx = 1'b1;
    @(negedge clk);
    total++; if (o_active !== 1'b1) begin bad++; $display("FAIL glitch_active_rise: got %b want 1", o_active); end
    n = 0;
    while (o_active && n < 55) begin @(negedge clk); n++; end
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL glitch_active_timeout: got active=%b after %0d cycles want 0", o_active, n); end
    repeat (200) @(posedge clk);
    @(negedge clk);
    total++; if (dv_cnt - b !== 0 || ferr_cnt - f !== 0) begin
      bad++; $display("FAIL glitch_pulses: got dv=%0d ferr=%0d want 0 0", dv_cnt - b, ferr_cnt - f); end
  endtask

  task automatic test_frame_err;
    int b, f;
    b = dv_cnt; f = ferr_cnt;
    send_frame(9'h03C, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (ferr_cnt - f !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f); end
    total++; if (dv_cnt - b !== 0) begin bad++; $display("FAIL ferr_no_dv: got %0d want 0", dv_cnt - b); end
    total++; if (o_data !== 9'h0A5) begin bad++; $display("FAIL ferr_data_kept: got %h want 0a5", o_data); end
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    total++; if (ferr_cnt - f !== 1 || dv_cnt - b !== 0 || o_active !== 1'b0) begin
      bad++; $display("FAIL break_quiet: got ferr=%0d dv=%0d active=%b want 1 0 0", ferr_cnt - f, dv_cnt - b, o_active); end
    rx = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp [3];
    int b, f, q0;
    exp[0] = 9'h001; exp[1] = 9'h1FF; exp[2] = 9'h100;
    b = dv_cnt; f = ferr_cnt; q0 = dq.size();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (dv_cnt - b !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", dv_cnt - b); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dq.size() <= q0 + i || dq[q0 + i] !== exp[i]) begin
        bad++; $display("FAIL b2b_word%0d: got %h want %h", i, (dq.size() > q0 + i) ? dq[q0 + i] : 9'h1xx, exp[i]); end
    end
    total++; if (o_data !== 9'h100) begin bad++; $display("FAIL b2b_hold: got %h want 100", o_data); end
    total++; if (ferr_cnt - f !== 0) begin bad++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f); end
    total++; if (long_cnt !== 0) begin bad++; $display("FAIL pulse_width: got %0d long pulses want 0", long_cnt); end
  endtask

  task automatic test_reset_midframe;
    int b, f;
    logic seen;
    // Frame 1E0: bits 0..4 low, 5..8 high, so no 1->0 edge follows bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    total++; if (o_active !== 1'b1) begin bad++; $display("FAIL mid_active: got %b want 1", o_active); end
    rst_n = 1'b0;
    #1;
    total++; if ({o_data, o_dv, o_active, o_frame_err, o_parity_err} !== 13'h0) begin
      bad++; $display("FAIL mid_reset_outputs: got data=%h flags=%b want 000 0000", o_data, {o_dv, o_active, o_frame_err, o_parity_err}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 * BIT + 50; i++) begin
      @(posedge clk);
      if (i == 50) rx = 1'b1;
      @(negedge clk);
      if (o_active) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_ignored: got active seen=%b want 0", seen); end
    b = dv_cnt; f = ferr_cnt;
    send_frame(9'h055, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (dv_cnt - b !== 1 || o_data !== 9'h055) begin
      bad++; $display("FAIL mid_next_frame: got dv=%0d data=%h want 1 055", dv_cnt - b, o_data); end
    total++; if (ferr_cnt - f !== 0) begin bad++; $display("FAIL mid_next_ferr: got %0d want 0", ferr_cnt - f); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int b, p;
    b = dv_cnt; p = perr_cnt;
    send_frame(9'h1A5, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (dv_cnt - b !== 1 || perr_cnt - p !== 1 || o_data !== 9'h1A5) begin
      bad++; $display("FAIL par_bad: got dv=%0d perr=%0d data=%h want 1 1 1a5", dv_cnt - b, perr_cnt - p, o_data); end
    b = dv_cnt; p = perr_cnt;
    send_frame(9'h0A5, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (dv_cnt - b !== 1 || perr_cnt - p !== 0) begin
      bad++; $display("FAIL par_good: got dv=%0d perr=%0d want 1 0", dv_cnt - b, perr_cnt - p); end
  endtask
`else
  task automatic test_parity;
    int b, p;
    b = dv_cnt; p = perr_cnt;
    send_frame(9'h1A5, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (dv_cnt - b !== 1 || perr_cnt - p !== 0 || o_data !== 9'h1A5) begin
      bad++; $display("FAIL par_off: got dv=%0d perr=%0d data=%h want 1 0 1a5", dv_cnt - b, perr_cnt - p, o_data); end
  endtask
`endif

  initial begin
    rx = 1'b1;
    rst_n = 1'b1;
    test_reset;
    test_loopback;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_midframe;
    test_parity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter p_CLK_DIV, default 104, SHALL set the bit period to p_CLK_DIV+1 i_clk cycles, matching the transmitter in this codebase.
REQ-002 Parameter p_WORD_LEN, default 8, SHALL set the frame to p_WORD_LEN+1 data bits, including parity when used.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_rx  input  1  serial line, asynchronous to i_clk, idle high.
REQ-006 o_data  output  p_WORD_LEN+1  last received word, LSB first on the line.
REQ-007 o_dv  output  1  one-cycle pulse marking o_data as newly valid.
REQ-008 o_active  output  1  high while a frame is being received.
REQ-009 o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 o_parity_err  output  1  one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-012 States SHALL be IDLE, START, DATA, STOP and DONE; any other encoding SHALL return to IDLE.
REQ-013 IDLE: clear the clock and bit counters; on rx_s==0 with previous rx_s==1 (falling edge), go to START and set o_active=1.
REQ-014 START: count up to p_CLK_DIV/2 (integer division); at that count, if rx_s==0, clear the counter and go to DATA; otherwise (glitch) go to IDLE with o_active=0 and no error pulse.
REQ-015 DATA: count to p_CLK_DIV; at that count, store rx_s into o_data-shadow bit[bit_count] and clear the counter; go to STOP after bit p_WORD_LEN, else increment bit_count.
REQ-016 Each data sample SHALL therefore fall at the centre of its bit, with bit k sampled (k+1)*(p_CLK_DIV+1) cycles after the start-bit centre.
REQ-017 STOP: count to p_CLK_DIV, then sample rx_s; if 1, copy the shadow register to o_data and pulse o_dv; if 0, pulse o_frame_err, leave o_data unchanged and do not pulse o_dv; then go to DONE.
REQ-018 o_dv and the error pulses SHALL assert in the cycle after the stop sample and last exactly one cycle.
REQ-019 DONE: set o_active=0 and go to IDLE in one cycle; a new start SHALL be accepted only after a fresh 1->0 edge, so a held-low break line produces one frame_err only.
REQ-020 Back-to-back frames with zero idle time between stop and next start SHALL be received without loss.
REQ-021 o_data SHALL hold its value until the next successful frame.
REQ-022 Counters SHALL be wide enough for p_CLK_DIV and p_WORD_LEN without wrap; widths derive from $clog2 of the parameters plus one bit.

Reset
REQ-023 Asserting i_rst_n low at any time, including mid-frame, SHALL immediately force state IDLE, counters 0, synchronizer flops 1, o_data 0, and o_dv, o_active, o_frame_err and o_parity_err all 0.
REQ-024 After reset release, a frame already in progress SHALL be ignored until a new falling edge is seen.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL control the parity check.
REQ-026 With UART_RX_PARITY_EN defined, bit p_WORD_LEN is treated as even parity over bits p_WORD_LEN-1:0; on a mismatch, o_parity_err pulses together with o_dv, and o_data is still updated.
REQ-027 Without UART_RX_PARITY_EN, o_parity_err SHALL be tied 0 and no parity logic is synthesized.

Structure
REQ-028 State encodings and the default p_CLK_DIV/p_WORD_LEN constants SHALL live in shared package uart_pkg, shared with the transmitter.
REQ-029 The synchronizer SHALL be a sub-module, uart_sync (2-flop, reset value parameterised, reset is asynchronous and active-low).

Verification
REQ-030 Loopback from the transmitter, p_CLK_DIV=104, p_WORD_LEN=8, sending 9'h0A5 -> one o_dv pulse with o_data=9'h0A5 and no error pulses.
REQ-031 A low glitch on i_rx lasting 20 cycles -> no o_dv, no o_frame_err, and o_active back to 0 within 55 cycles.
REQ-032 Frame 9'h03C sent with the stop bit forced low -> o_frame_err pulses, o_dv stays 0, and o_data keeps its prior value; the line held low afterwards -> no further pulses.
REQ-033 Frames 9'h001, 9'h1FF, 9'h100 sent back-to-back -> three o_dv pulses in order with matching o_data.
REQ-034 i_rst_n pulsed low mid-frame (during bit 4) -> all outputs 0 immediately; the next full frame 9'h055 is received correctly.
REQ-035 With UART_RX_PARITY_EN defined, frame 9'h1A5 -> o_dv with o_parity_err=1; frame 9'h0A5 -> o_parity_err=0.
